pipe_sub3_hs: RTL and testbench
===============================

# pipe_sub3_hs

Three-operand pipelined subtractor computing `diff = a - b - c` modulo 2^16 with an underflow flag. It is the inverse-direction companion to the three-operand pipelined adder. Both stages are edge-triggered registers with valid/ready flow control, so it can sit between producer and consumer blocks that stall. Throughput is one operation per cycle and latency is two cycles.

## Interface
- `WIDTH`, default 16: operand and result width.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `in_valid` input, 1: `a`, `b`, `c` are valid this cycle.
- `in_ready` output, 1: block accepts the operand triple this cycle.
- `a`, `b`, `c` input, WIDTH each: unsigned operands.
- `out_valid` output, 1: `diff` and `uflow` are valid.
- `out_ready` input, 1: consumer accepts the result this cycle.
- `diff` output, WIDTH: `(a - b - c) mod 2^WIDTH`.
- `uflow` output, 1: the true integer result `a - b - c` is negative.

## Operation
- Stage 1 register (S1) holds:
  - `v1`
  - `d_ab = a - b` (WIDTH bits)
  - `bw1 = (a < b)`
  - `c1 = c`
- Stage 2 register (S2) holds:
  - `v2`
  - `diff = d_ab - c1`
  - `uflow = bw1 | (d_ab < c1)`
- Advance rule per stage is `ready_k = !v_k | ready_{k+1}`, with `ready_3 = out_ready`.
  - `in_ready = ready_1`, which is combinational from `out_ready` through the chain.
- S1 loads when `ready_1` is high: `v1 <= in_valid`. Data loads only when `in_valid & in_ready`.
- S2 loads when `ready_2` is high: `v2 <= v1`. Data loads only when `v1 & ready_2`.
- Data registers hold their value while their stage is stalled.
- Transfer on each side occurs only when valid and ready are high in the same cycle.
  - A held `out_valid` with `out_ready` low keeps `diff`/`uflow` stable until accepted.
- `out_valid = v2`.
- Arithmetic:
  - Unsigned, wrap-around modulo 2^WIDTH.
  - No saturation.
  - The borrow of each subtraction is the carry-out inverted.
- `uflow` is exact for all operand values.
  - If `bw1 = 1` the true result is negative regardless of `c`.
  - Otherwise `uflow` equals the second-stage borrow.

## Timing
- Reset (async assert, `rst_n` low):
  - `v1`, `v2`, all data registers cleared to 0.
  - `out_valid = 0`, `diff = 0`, `uflow = 0`.
  - `in_ready` is 1 once reset is released, and follows the ready chain (it is 1 whenever S1 is empty).
- Reset mid-operation:
  - In-flight results are discarded.
  - No output is produced for operands accepted before reset.
  - Release is synchronous to the next `clk` edge.
- Latency: operand accepted at edge N gives `out_valid` high after edge N+2 with no stall.
- Full pipeline (`v1 = v2 = 1`) with `out_ready` low:
  - `in_ready = 0`.
  - Nothing is overwritten.
- Full pipeline with `out_ready` high: accept, shift and emit happen in the same cycle, sustaining 1/cycle.
- Bubble (`v2 = 0`, `v1 = 1`) with `out_ready` low: S1 moves into S2, and `in_ready` stays 1.
- Empty pipeline: `in_ready = 1` regardless of `out_ready`.

## Structure
- Shared package `pipe_arith_pkg` holds:
  - `localparam` default `WIDTH = 16`
  - typedef `word_t` (`logic [WIDTH-1:0]`)
  - a `stage_t` struct `{valid, data, borrow}`, reused by the adder and subtractor pipelines.
- One sub-module, `subripple_n #(WIDTH)`:
  - Ripple-borrow subtractor with ports `a`, `b`, `d`, `bout`.
  - Instantiated twice: stage 1 `a - b`, stage 2 `d_ab - c1`.
- Flow control is written inline in the top module. There is no separate skid buffer.

## Test plan
- Basic, `out_ready = 1`:
  - `a = 100`, `b = 30`, `c = 20`.
  - Expect `diff = 50`, `uflow = 0`, `out_valid` 2 cycles after accept.
- Underflow:
  - `a = 5`, `b = 3`, `c = 4` gives `diff = 0xFFFE`, `uflow = 1`.
  - `a = 0`, `b = 0xFFFF`, `c = 0xFFFF` gives `diff = 0x0002`, `uflow = 1`.
  - `a = 0xFFFF`, `b = 0x8000`, `c = 0x7FFF` gives `diff = 0`, `uflow = 0`.
- Streaming:
  - 8 back-to-back triples `(a = 1000 + i, b = i, c = 2*i)` with `out_ready = 1`.
  - Expect 8 consecutive results `1000 - 2*i`, one per cycle, with no gaps.
- Backpressure:
  - Hold `out_ready = 0` for 5 cycles while driving 3 triples.
  - Expect exactly 2 accepted, `in_ready = 0` after that, and `diff` stable.
  - On release, the results drain in order with no loss or duplication.
- Reset mid-flight:
  - Assert `rst_n = 0` asynchronously with 2 ops in flight.
  - Expect `out_valid`, `diff`, `uflow` to go to 0 immediately.
  - Expect no stale result after release.
- Random:
  - 10k random triples with random `in_valid`/`out_ready`.
  - Compare against a reference queue model using `(a - b - c) mod 65536` and the sign of the integer result.

Source files
------------

// File: rtl/pipe_arith_pkg.sv
// Shared definitions for the three-operand adder/subtractor pipelines.
// Default operand width plus the stage payload type both pipelines carry.
package pipe_arith_pkg;

   localparam int WIDTH = 16;

   typedef logic [WIDTH-1:0] word_t;

   typedef struct packed {
      logic  valid;
      word_t data;
      logic  borrow;
   } stage_t;

endpackage

// File: rtl/pipe_sub3_hs_subripple_n.sv
// Ripple-borrow subtractor: d = a - b mod 2^WIDTH, bout set when a < b.
module subripple_n #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   logic br;

   always_comb begin
      d  = '0;
      br = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         d[i] = a[i] ^ b[i] ^ br;
         br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
      end
      bout = br;
   end

endmodule

// File: rtl/pipe_sub3_hs.sv
// Two-stage valid/ready pipelined subtractor: diff = a - b - c mod 2^WIDTH,
// uflow flags a negative integer result.
module pipe_sub3_hs
   import pipe_arith_pkg::*;
#(
   parameter int WIDTH = pipe_arith_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             uflow
);

   logic             vld_p1, vld_p2;
   logic [WIDTH-1:0] d_ab_p1, c_p1, diff_p2;
   logic             bw_p1, uflow_p2;
   logic             rdy_p1, rdy_p2;
   logic [WIDTH-1:0] d_ab, d_abc;
   logic             bw_ab, bw_c;

   // A stage can load when it is empty or its successor is draining it.
   assign rdy_p2   = !vld_p2 | out_ready;
   assign rdy_p1   = !vld_p1 | rdy_p2;
   assign in_ready = rdy_p1;

   subripple_n #(.WIDTH(WIDTH)) u_sub_ab (
      .a    (a),
      .b    (b),
      .d    (d_ab),
      .bout (bw_ab)
   );

   subripple_n #(.WIDTH(WIDTH)) u_sub_c (
      .a    (d_ab_p1),
      .b    (c_p1),
      .d    (d_abc),
      .bout (bw_c)
   );

   // Stage 1: a - b with its borrow, c carried alongside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         d_ab_p1 <= '0;
         bw_p1   <= 1'b0;
         c_p1    <= '0;
      end else if (rdy_p1) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            d_ab_p1 <= d_ab;
            bw_p1   <= bw_ab;
            c_p1    <= c;
         end
      end
   end

   // Stage 2: subtract c; a stage-1 borrow already proves the result negative
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2   <= 1'b0;
         diff_p2  <= '0;
         uflow_p2 <= 1'b0;
      end else if (rdy_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            diff_p2  <= d_abc;
            uflow_p2 <= bw_p1 | bw_c;
         end
      end
   end

   assign out_valid = vld_p2;
   assign diff      = diff_p2;
   assign uflow     = uflow_p2;

endmodule

// File: tb/tb_pipe_sub3_hs.sv
// Self-checking bench for pipe_sub3_hs: directed scenarios plus a randomized
// valid/ready run scored against an integer-arithmetic queue model.
module tb_pipe_sub3_hs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, uflow;
   logic [15:0] a, b, c, diff;

   int checks = 0;
   int errors = 0;

   // expected results in acceptance order: {uflow, diff}
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_sub3_hs #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .uflow     (uflow)
   );

   function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
      int          r;
      logic [31:0] rv;
      r  = int'(x) - int'(y) - int'(z);
      rv = r;
      return {(r < 0), rv[15:0]};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = '0;
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || diff !== 16'h0 || uflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b diff=%h uflow=%b, want 0/0000/0",
                  out_valid, diff, uflow);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle(); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      a = 16'd100; b = 16'd30; c = 16'd20; in_valid = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_in_ready: got %b want 1", in_ready);
      end
      next_cycle();
      in_valid = 1'b0; #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency1: out_valid=%b after one edge, want 0", out_valid);
      end
      next_cycle(); #1;
      checks++;
      if (out_valid !== 1'b1 || diff !== 16'd50 || uflow !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got v=%b diff=%0d uflow=%b, want 1/50/0", out_valid, diff, uflow);
      end
      next_cycle(); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: out_valid=%b after accept, want 0", out_valid);
      end
   endtask

   task automatic test_underflow();
      logic [15:0] va[3] = '{16'd5, 16'h0000, 16'hFFFF};
      logic [15:0] vb[3] = '{16'd3, 16'hFFFF, 16'h8000};
      logic [15:0] vc[3] = '{16'd4, 16'hFFFF, 16'h7FFF};
      logic [15:0] ed[3] = '{16'hFFFE, 16'h0002, 16'h0000};
      logic        eu[3] = '{1'b1, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = va[k]; b = vb[k]; c = vc[k]; in_valid = 1'b1;
         next_cycle();
         in_valid = 1'b0;
         next_cycle(); #1;
         checks++;
         if (out_valid !== 1'b1 || diff !== ed[k] || uflow !== eu[k]) begin
            errors++;
            $display("FAIL underflow_%0d: got v=%b diff=%h uflow=%b, want 1/%h/%b",
                     k, out_valid, diff, uflow, ed[k], eu[k]);
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      int got = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         checks++;
         if (out_valid !== (cyc >= 2 && cyc < 10)) begin
            errors++;
            $display("FAIL stream_valid_c%0d: got %b want %b", cyc, out_valid, (cyc >= 2 && cyc < 10));
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (diff !== 16'(1000 - 2 * got) || uflow !== 1'b0) begin
               errors++;
               $display("FAIL stream_data_%0d: got diff=%0d uflow=%b want %0d/0",
                        got, diff, uflow, 1000 - 2 * got);
            end
            got++;
         end
         in_valid = (cyc < 8);
         a = 16'(1000 + cyc); b = 16'(cyc); c = 16'(2 * cyc); #1;
         if (cyc < 8) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream_in_ready_c%0d: got %b want 1", cyc, in_ready);
            end
         end
         next_cycle();
      end
      in_valid = 1'b0;
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL stream_count: got %0d results want 8", got);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ta[3], tb[3], tc[3];
      logic [15:0] held;
      int          sent = 0, rcv = 0, budget = 0;
      for (int k = 0; k < 3; k++) begin
         ta[k] = 16'($urandom); tb[k] = 16'($urandom); tc[k] = 16'($urandom);
      end
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         a = ta[sent]; b = tb[sent]; c = tc[sent]; in_valid = 1'b1; #1;
         if (cyc >= 2) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready_c%0d: got %b want 0", cyc, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || {uflow, diff} !== model(ta[0], tb[0], tc[0])) begin
               errors++;
               $display("FAIL bp_hold_c%0d: got v=%b %b/%h want 1 %h", cyc, out_valid,
                        uflow, diff, model(ta[0], tb[0], tc[0]));
            end
            if (cyc > 2) begin
               checks++;
               if (diff !== held) begin
                  errors++;
                  $display("FAIL bp_stable_c%0d: diff %h changed from %h", cyc, diff, held);
               end
            end
            held = diff;
         end
         if (in_ready === 1'b1) sent++;
         next_cycle();
      end
      checks++;
      if (sent != 2) begin
         errors++;
         $display("FAIL bp_accept_count: got %0d want 2", sent);
      end
      out_ready = 1'b1;
      while (rcv < 3 && budget < 12) begin
         in_valid = (sent < 3);
         a = ta[2]; b = tb[2]; c = tc[2]; #1;
         if (out_valid === 1'b1) begin
            checks++;
            if ({uflow, diff} !== model(ta[rcv], tb[rcv], tc[rcv])) begin
               errors++;
               $display("FAIL bp_drain_%0d: got %h want %h", rcv, {uflow, diff},
                        model(ta[rcv], tb[rcv], tc[rcv]));
            end
            rcv++;
         end
         if (in_valid && in_ready === 1'b1) sent++;
         budget++;
         next_cycle();
      end
      in_valid = 1'b0;
      checks++;
      if (rcv != 3) begin
         errors++;
         $display("FAIL bp_drain_count: got %0d results want 3", rcv);
      end
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_duplicate: out_valid=%b after drain, want 0", out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a = 16'(500 + k); b = 16'd1; c = 16'd1; in_valid = 1'b1;
         next_cycle();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || diff !== 16'h0 || uflow !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_clear: got v=%b diff=%h uflow=%b rdy=%b want 0/0000/0/1",
                  out_valid, diff, uflow, in_ready);
      end
      next_cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         next_cycle(); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale_c%0d: out_valid=%b want 0", cyc, out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [16:0] exp, held;
      logic        held_vld = 1'b0;
      logic        pending = 1'b0;
      int          budget = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (!pending) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
            if ($urandom_range(0, 7) == 0) c = 16'h0;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         checks++;
         if (in_ready !== !(exp_q.size() == 2 && !out_ready)) begin
            errors++;
            $display("FAIL rand_in_ready_c%0d: got %b with %0d in flight, out_ready=%b",
                     cyc, in_ready, exp_q.size(), out_ready);
         end
         if (held_vld) begin
            checks++;
            if (out_valid !== 1'b1 || {uflow, diff} !== held) begin
               errors++;
               $display("FAIL rand_stall_c%0d: got v=%b %h want 1 %h", cyc, out_valid, {uflow, diff}, held);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious_c%0d: output %h with nothing in flight", cyc, {uflow, diff});
            end else begin
               exp = exp_q.pop_front();
               if ({uflow, diff} !== exp) begin
                  errors++;
                  $display("FAIL rand_data_c%0d: got %h want %h", cyc, {uflow, diff}, exp);
               end
            end
         end
         held_vld = (out_valid === 1'b1 && !out_ready);
         held     = {uflow, diff};
         if (in_valid && in_ready === 1'b1) exp_q.push_back(model(a, b, c));
         pending = in_valid && in_ready !== 1'b1;
         next_cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      while (exp_q.size() != 0 && budget < 20) begin
         #1;
         if (out_valid === 1'b1) begin
            exp = exp_q.pop_front();
            checks++;
            if ({uflow, diff} !== exp) begin
               errors++;
               $display("FAIL rand_drain: got %h want %h", {uflow, diff}, exp);
            end
         end
         budget++;
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain_timeout: %0d results never emerged", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
